// File: rtl/alu_multicycle_seq_if.sv
// Request/response bundle between the EX-stage control FSM (master) and the
// iterative ALU (slave).
interface alu_multicycle_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] data_out;
    logic             zero_flag;
    logic             dbz_flag;
    logic             busy;
    logic             done;

    modport master (
        output start, opcode, rs, rt,
        input  data_out, zero_flag, dbz_flag, busy, done
    );

    modport slave (
        input  start, opcode, rs, rt,
        output data_out, zero_flag, dbz_flag, busy, done
    );
endinterface

// File: rtl/alu_multicycle_seq.sv
// Clocked ALU: single-cycle arithmetic/logic ops plus iterative shift-add
// multiply and restoring unsigned divide/remainder, one bit per cycle.
module alu_multicycle_seq #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_multicycle_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_DIVU = 4'b0111;
    localparam logic [3:0] OP_REMU = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] iter_res;

    function automatic logic [WIDTH-1:0] single_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = ($signed(x) < $signed(y)) ? WIDTH'(1) : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            zero_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            zero_q     <= zero_d;
            dbz_q      <= dbz_d;
        end
    end

    // MUL: a = multiplicand (shifts left), b = multiplier (shifts right), acc = product.
    // DIV: a = dividend/quotient (shifts left), b = divisor, acc = partial remainder.
    // A zero divisor makes div_ge always true, which naturally yields an
    // all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        mul_sum    = acc_q + (b_q[0] ? a_q : '0);
        rem_shift  = {acc_q, a_q[WIDTH-1]};
        div_ge     = (rem_shift >= {1'b0, b_q});
        rem_sub    = rem_shift - {1'b0, b_q};
        rem_next   = div_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next   = {a_q[WIDTH-2:0], div_ge};
        single_res = single_op(bus.opcode, bus.rs, bus.rt);
        iter_res   = (op_q == OP_REMU) ? rem_next : quo_next;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        zero_d     = zero_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    op_d  = bus.opcode;
                    a_d   = bus.rs;
                    b_d   = bus.rt;
                    acc_d = '0;
                    cnt_d = '0;
                    if (bus.opcode == OP_MUL) begin
                        state_d = S_MUL;
                    end else if (bus.opcode == OP_DIVU || bus.opcode == OP_REMU) begin
                        state_d = S_DIV;
                    end else begin
                        state_d    = S_DONE;
                        data_out_d = single_res;
                        zero_d     = (single_res == '0);
                        dbz_d      = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_MUL: begin
                acc_d = mul_sum;
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = S_DONE;
                    data_out_d = mul_sum;
                    zero_d     = (mul_sum == '0);
                    dbz_d      = 1'b0;
                end
            end

            S_DIV: begin
                acc_d = rem_next;
                a_d   = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = S_DONE;
                    data_out_d = iter_res;
                    zero_d     = (iter_res == '0);
                    dbz_d      = (b_q == '0);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data_out  = data_out_q;
    assign bus.zero_flag = zero_q;
    assign bus.dbz_flag  = dbz_q;
    assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_alu_multicycle_seq.sv
// Directed bench for alu_multicycle_seq at WIDTH=32: latency, results, flags,
// start-ignoring while busy and mid-operation reset.
module tb_alu_multicycle_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   overlap = 0;
    int   lat;
    int   busy_cycles;
    int   done_pulses;

    alu_multicycle_seq_if #(.WIDTH(32)) bus ();

    alu_multicycle_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.busy && bus.done) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one request; returns in the cycle after the sampling edge E0.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.rs     = a;
        bus.rt     = b;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busy_seen);
        cycles = 0;
        busy_seen = 0;
        while (!bus.done && cycles < 100) begin
            if (bus.busy) busy_seen++;
            tick();
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_data,
                         input logic exp_zero, input logic exp_dbz);
        applyStimulus(op, a, b);
        waitDone(lat, busy_cycles);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, exp_lat);
        checkOutput({tag, "_data"}, bus.data_out, exp_data);
        checkOutput({tag, "_zero"}, 32'(bus.zero_flag), 32'(exp_zero));
        checkOutput({tag, "_dbz"}, 32'(bus.dbz_flag), 32'(exp_dbz));
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.opcode = 4'h0;
        bus.rs     = '0;
        bus.rt     = '0;

        repeat (2) tick();
        checkOutput("reset_data", bus.data_out, 32'h0);
        checkOutput("reset_zero", 32'(bus.zero_flag), 32'h0);
        checkOutput("reset_dbz", 32'(bus.dbz_flag), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_done", 32'(bus.done), 32'h0);
        rst = 1'b0;
        tick();

        // ADD wrap, then SUB issued in the done cycle
        applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'h1);
        checkOutput("add_done", 32'(bus.done), 32'h1);
        checkOutput("add_busy", 32'(bus.busy), 32'h0);
        checkOutput("add_data", bus.data_out, 32'h0);
        checkOutput("add_zero", 32'(bus.zero_flag), 32'h1);
        applyStimulus(4'b0001, 32'd5, 32'd5);
        checkOutput("sub_done", 32'(bus.done), 32'h1);
        checkOutput("sub_data", bus.data_out, 32'h0);
        checkOutput("sub_zero", 32'(bus.zero_flag), 32'h1);
        tick();
        checkOutput("done_single_pulse", 32'(bus.done), 32'h0);

        runOp("mul_7x6", 4'b0010, 32'd7, 32'd6, 32, 32'd42, 1'b0, 1'b0);
        runOp("mul_wrap", 4'b0010, 32'h0001_0000, 32'h0001_0000, 32, 32'h0, 1'b1, 1'b0);
        runOp("divu_100_7", 4'b0111, 32'd100, 32'd7, 32, 32'd14, 1'b0, 1'b0);
        runOp("remu_100_7", 4'b1000, 32'd100, 32'd7, 32, 32'd2, 1'b0, 1'b0);
        runOp("divu_by0", 4'b0111, 32'd9, 32'd0, 32, 32'hFFFF_FFFF, 1'b0, 1'b1);
        runOp("remu_by0", 4'b1000, 32'd9, 32'd0, 32, 32'd9, 1'b0, 1'b1);
        runOp("add_clear_dbz", 4'b0000, 32'd1, 32'd2, 0, 32'd3, 1'b0, 1'b0);
        runOp("slt_neg", 4'b0110, 32'hFFFF_FFFE, 32'd3, 0, 32'd1, 1'b0, 1'b0);
        runOp("slt_swap", 4'b0110, 32'd3, 32'hFFFF_FFFE, 0, 32'd0, 1'b1, 1'b0);
        runOp("and", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200, 1'b0, 1'b0);
        runOp("or", 4'b0100, 32'hF000_0001, 32'h0000_0010, 0, 32'hF000_0011, 1'b0, 1'b0);
        runOp("xor", 4'b0101, 32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555, 1'b0, 1'b0);
        runOp("illegal_op", 4'b1111, 32'd123, 32'd45, 0, 32'h0, 1'b1, 1'b0);

        // MUL 3*5 with a stray start and operand changes mid-operation
        applyStimulus(4'b0010, 32'd3, 32'd5);
        repeat (9) tick();
        bus.start  = 1'b1;
        bus.opcode = 4'b0000;
        bus.rs     = 32'd1;
        bus.rt     = 32'd1;
        tick();
        bus.start  = 1'b0;
        bus.rs     = 32'd123;
        bus.rt     = 32'd456;
        waitDone(lat, busy_cycles);
        checkOutput("mul_ignore_latency", lat + 10, 32);
        checkOutput("mul_ignore_data", bus.data_out, 32'd15);

        // Reset in the middle of a DIVU abandons it silently
        applyStimulus(4'b0111, 32'd100, 32'd7);
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_data", bus.data_out, 32'h0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
        checkOutput("midrst_done", 32'(bus.done), 32'h0);
        checkOutput("midrst_zero", 32'(bus.zero_flag), 32'h0);
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) done_pulses++;
            tick();
        end
        checkOutput("midrst_no_done", done_pulses, 0);
        runOp("add_after_rst", 4'b0000, 32'd2, 32'd2, 0, 32'd4, 1'b0, 1'b0);

        checkOutput("busy_done_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
